// File: rtl/if_prefetch.sv
// Instruction-fetch front end: issues sequential fetches, buffers {pc, ir} in a
// small FIFO, and discards in-flight responses after a branch/jal/jalr redirect.
module if_prefetch #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [PC_W-1:0]             imem_addr,
  input  logic                        imem_resp_valid,
  input  logic [31:0]                 imem_resp_data,
  input  logic                        br_jal_success,
  input  logic [PC_W-1:0]             br_jal_pc,
  input  logic                        alu_to_pc,
  input  logic [PC_W-1:0]             alu_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [31:0]                 ir,
  output logic [PC_W-1:0]             pc,
  output logic [PC_W-1:0]             ra,
  output logic [PC_W-1:0]             npc,
  output logic [$clog2(FQ_DEPTH)+1-1:0] fq_count
);
  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int AW = $clog2(FQ_DEPTH);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
  } fq_entry_t;

  fq_entry_t       fq_mem [FQ_DEPTH];
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;

  logic            redirect;
  logic [PC_W-1:0] target;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            push;
  logic            pop;
  fq_entry_t       head;

  assign redirect = br_jal_success | alu_to_pc;
  assign target   = br_jal_success ? br_jal_pc : {alu_out[PC_W-1:1], 1'b0};

  // Buffered entries plus responses still owed to the queue bound new requests.
  assign credit_used    = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_q};
  assign imem_req_valid = !rst && !redirect && (credit_used < (CW+1)'(FQ_DEPTH));
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready & !redirect;
  assign push      = imem_resp_valid & (drop_q == '0) & !redirect;

  assign head     = fq_mem[rd_ptr_q];
  assign pc       = out_valid ? head.pc : '0;
  assign ir       = out_valid ? head.ir : '0;
  assign ra       = pc + PC_W'(4);
  assign npc      = fetch_pc_d;
  assign fq_count = count_q;

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      inflight_d = inflight_q - CW'(imem_resp_valid);
      drop_d     = inflight_q - CW'(imem_resp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_W'(4);
      inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
      if (imem_resp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
      if (push) begin
        resp_pc_d = resp_pc_q + PC_W'(4);
        wr_ptr_d  = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // NOTE: queue storage has no reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) fq_mem[wr_ptr_q] <= '{pc: resp_pc_q, ir: imem_resp_data};
  end
endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: latency-programmable memory model plus a scoreboard
// queue of expected head PCs consumed by an independent monitor.
module tb_if_prefetch;
  localparam int PC_W  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            br_jal_success;
  logic [PC_W-1:0] br_jal_pc;
  logic            alu_to_pc;
  logic [PC_W-1:0] alu_out;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     ir;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] ra;
  logic [PC_W-1:0] npc;
  logic [2:0]      fq_count;

  if_prefetch #(.PC_W(PC_W), .RESET_PC(32'h0), .FQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .br_jal_success(br_jal_success),
    .br_jal_pc(br_jal_pc), .alu_to_pc(alu_to_pc), .alu_out(alu_out),
    .out_valid(out_valid), .out_ready(out_ready), .ir(ir), .pc(pc), .ra(ra),
    .npc(npc), .fq_count(fq_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory model: in-order responses, each 'lat' cycles after its acceptance edge.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    lat = 1;

  always @(negedge clk)
    if (!rst && imem_req_valid && imem_req_ready) mq.push_back('{imem_addr, cyc + 1 + lat});

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        mq.delete();
        imem_resp_valid = 1'b0;
      end else if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
    end
  end

  // Scoreboard: decode only accepts while an expected entry is outstanding.
  logic [31:0] exp_q[$];
  logic        want_ready = 1'b0;
  logic        rand_stall = 1'b0;
  int          last_pop_cyc = 0;
  logic [31:0] exp_pc;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = want_ready && (exp_q.size() > 0) &&
                  !(rand_stall && ($urandom_range(0, 2) == 0));
    end
  end

  always @(negedge clk) begin
    if (!rst) check("fq_count_bound", 64'(fq_count <= 3'(DEPTH)), 64'd1);
    if (out_valid && out_ready && !br_jal_success && !alu_to_pc) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got pc 0x%0h expected none", pc);
      end else begin
        exp_pc = exp_q.pop_front();
        check("pop_pc", 64'(pc), 64'(exp_pc));
        check("pop_ir", 64'(ir), 64'(mem_word(exp_pc)));
        check("pop_ra", 64'(ra), 64'(exp_pc + 32'd4));
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int start;
    int n;
    imem_req_ready = 1'b1;
    br_jal_success = 1'b0;
    br_jal_pc      = '0;
    alu_to_pc      = 1'b0;
    alu_out        = '0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fq_count", 64'(fq_count), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_npc", 64'(npc), 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_ra", 64'(ra), 64'd4);
    check("rst_ir", 64'(ir), 64'd0);
    tick(2);

    // T1: L=1 streaming, first-out latency and 1/cycle throughput
    lat = 1;
    expect_run(32'h0, 8);
    want_ready = 1'b1;
    rst = 1'b0;
    c = -1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (c < 0 && imem_req_valid && imem_req_ready) begin
        c = cyc;
        check("t1_first_addr", 64'(imem_addr), 64'h0);
      end
      if (c >= 0 && out_valid) break;
    end
    check("t1_latency", 64'(cyc - c), 64'd2);
    start = cyc;
    drain("t1_drain", 50);
    check("t1_throughput", 64'(last_pop_cyc - start), 64'd7);

    // T2: stall fills the queue and throttles requests; resume without loss
    want_ready = 1'b0;
    repeat (12) @(negedge clk);
    check("t2_full", 64'(fq_count), 64'd4);
    check("t2_req_blocked", 64'(imem_req_valid), 64'd0);
    check("t2_head_pc", 64'(pc), 64'h20);
    expect_run(32'h20, 8);
    want_ready = 1'b1;
    drain("t2_drain", 50);

    // T3: L=3, redirect with three responses in flight
    want_ready = 1'b0;
    tick(1);
    imem_req_ready = 1'b0;
    tick(6);
    lat = 3;
    br_jal_success = 1'b1;
    br_jal_pc      = 32'h80;
    tick(1);
    br_jal_success = 1'b0;
    tick(2);
    imem_req_ready = 1'b1;
    tick(3);
    imem_req_ready = 1'b0;
    br_jal_success = 1'b1;
    br_jal_pc      = 32'h100;
    @(negedge clk);
    check("t3_redirect_npc", 64'(npc), 64'h100);
    check("t3_redirect_noreq", 64'(imem_req_valid), 64'd0);
    tick(1);
    br_jal_success = 1'b0;
    imem_req_ready = 1'b1;
    expect_run(32'h100, 8);
    want_ready = 1'b1;
    @(negedge clk);
    check("t3_target_req", 64'(imem_req_valid), 64'd1);
    check("t3_target_addr", 64'(imem_addr), 64'h100);
    drain("t3_drain", 80);

    // T4: br_jal beats jalr; jalr alone clears bit 0; last redirect wins
    want_ready = 1'b0;
    tick(1);
    br_jal_success = 1'b1;
    br_jal_pc      = 32'h200;
    alu_to_pc      = 1'b1;
    alu_out        = 32'h301;
    @(negedge clk);
    check("t4_both_npc", 64'(npc), 64'h200);
    check("t4_both_noreq", 64'(imem_req_valid), 64'd0);
    tick(1);
    br_jal_success = 1'b0;
    @(negedge clk);
    check("t4_alu_npc", 64'(npc), 64'h300);
    tick(1);
    alu_to_pc = 1'b0;
    expect_run(32'h300, 8);
    want_ready = 1'b1;
    @(negedge clk);
    check("t4_target_addr", 64'(imem_addr), 64'h300);
    drain("t4_drain", 80);

    // T5: L=1 with random decode stalls, order preserved over 100 entries
    lat = 1;
    rand_stall = 1'b1;
    expect_run(32'h320, 100);
    drain("t5_drain", 2000);
    rand_stall = 1'b0;

    // T6: asynchronous reset mid-stream, fetch restarts at RESET_PC
    want_ready = 1'b0;
    lat = 3;
    n = 0;
    while (fq_count < 3'd3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t6_filled", 64'(fq_count >= 3'd3), 64'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_out_valid", 64'(out_valid), 64'd0);
    check("t6_rst_fq_count", 64'(fq_count), 64'd0);
    check("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("t6_rst_addr", 64'(imem_addr), 64'h0);
    check("t6_rst_npc", 64'(npc), 64'h0);
    check("t6_rst_ra", 64'(ra), 64'd4);
    tick(1);
    exp_q.delete();
    expect_run(32'h0, 8);
    want_ready = 1'b1;
    tick(1);
    rst = 1'b0;
    drain("t6_drain", 100);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
